// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared MUX4to1, with hold timeout and guard gap.
// Optional LOCK input (freezes hold timer, blocks preemption) enabled by defining MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD     = 8,
  parameter int GUARD_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
`ifdef MUX4_ARB_LOCK_EN
  input  logic       LOCK,
`endif
  output logic [3:0] GNT,
  output logic       VALID,
  output logic       CTRL1,
  output logic       CTRL2,
  output logic [1:0] OWNER
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST  = (MAX_HOLD > 0)     ? CNT_W'(MAX_HOLD - 1)     : '0;
  localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] guard_q, guard_d;

  logic [1:0] arb_base;
  logic [1:0] arb_idx;
  logic [1:0] arb_win;
  logic       arb_found;
  logic       lock_act;
  logic       others_req;
  logic       preempt;
  logic       release_own;

`ifdef MUX4_ARB_LOCK_EN
  assign lock_act = LOCK;
`else
  assign lock_act = 1'b0;
`endif

  // While granted the search starts after the current owner; elsewhere from the stored pointer.
  assign arb_base = (state_q == S_GRANT) ? owner_q + 2'd1 : ptr_q;

  always_comb begin
    arb_found = 1'b0;
    arb_win   = arb_base;
    arb_idx   = arb_base;
    for (int k = 3; k >= 0; k--) begin
      arb_idx = arb_base + 2'(k);
      if (REQ[arb_idx]) begin
        arb_found = 1'b1;
        arb_win   = arb_idx;
      end
    end
  end

  assign others_req  = |(REQ & ~gnt_q);
  assign preempt     = (MAX_HOLD > 0) && !lock_act && (hold_q >= HOLD_LAST) && others_req;
  assign release_own = !REQ[owner_q] || preempt;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    guard_d = guard_q;
    case (state_q)
      S_GRANT: begin
        if (release_own) begin
          ptr_d = owner_q + 2'd1;
          if (GUARD_CYCLES == 0) begin
            if (arb_found) begin
              state_d = S_GRANT;
              gnt_d   = 4'b0001 << arb_win;
              owner_d = arb_win;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
              gnt_d   = 4'b0000;
            end
          end else begin
            state_d = S_GUARD;
            gnt_d   = 4'b0000;
            guard_d = '0;
          end
        end else if (!lock_act && (hold_q != {CNT_W{1'b1}})) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (guard_q >= GUARD_LAST) begin
          if (arb_found) begin
            state_d = S_GRANT;
            gnt_d   = 4'b0001 << arb_win;
            owner_d = arb_win;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: begin
        gnt_d = 4'b0000;
        if (arb_found) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << arb_win;
          owner_d = arb_win;
          hold_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      guard_q <= guard_d;
    end
  end

  assign GNT   = gnt_q;
  assign VALID = |gnt_q;
  assign CTRL1 = owner_q[1];
  assign CTRL2 = owner_q[0];
  assign OWNER = owner_q;

endmodule
